// File: rtl/hub_special_case_pipe.sv
// hub_special_case_pipe
//   Two-stage pipeline that classifies a pair of HUB floating-point operands
//   and works out the special-case product. When the product can be given
//   without the main multiplier, bypass=1 and sc_result holds that product.
//   Special cases: inf, zero and (optionally) +/-1.
//
//   Optional feature: define HUB_SC_ONE_DETECT_EN to enable detection of
//   +/-1 operands (class codes 5/6) and the "multiply by one" shortcuts.
//   When it is undefined, +/-1 operands classify as 0 (none).
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input handshake for X, Y, in_tag
//   X, Y                HUB operands, sign at MSB
//   in_tag              opaque tag carried with the pair
//   out_valid/out_ready output handshake
//   x_case, y_case      class codes: 0 none, 1 +inf, 2 -inf, 3 +0, 4 -0,
//                       5 +1, 6 -1
//   bypass, invalid_op  special result valid / inf*zero detected
//   sc_result           special product (0 when bypass=0)
//   out_tag             tag of the output entry
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. A source holding valid keeps its payload stable until the transfer
// happens. in_ready never depends on in_valid. While out_valid=1 and
// out_ready=0, every output holds.
module hub_special_case_pipe #(
    parameter int M     = 23,
    parameter int E     = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [E+M:0]     X,
    input  logic [E+M:0]     Y,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       x_case,
    output logic [2:0]       y_case,
    output logic             bypass,
    output logic             invalid_op,
    output logic [E+M:0]     sc_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int W = E + M + 1;

    localparam logic [2:0] CASE_NONE = 3'd0;
    localparam logic [2:0] CASE_PINF = 3'd1;
    localparam logic [2:0] CASE_NINF = 3'd2;
    localparam logic [2:0] CASE_PZER = 3'd3;
    localparam logic [2:0] CASE_NZER = 3'd4;
`ifdef HUB_SC_ONE_DETECT_EN
    localparam logic [2:0] CASE_PONE = 3'd5;
    localparam logic [2:0] CASE_NONE1 = 3'd6;
`endif

    // Classify one operand from its magnitude bits; sign picks +/- code.
    function automatic logic [2:0] classify(input logic [W-1:0] v);
        logic [W-2:0] mag;
        mag = v[W-2:0];
        classify = CASE_NONE;
        if (&mag)
            classify = v[W-1] ? CASE_NINF : CASE_PINF;
        else if (mag == '0)
            classify = v[W-1] ? CASE_NZER : CASE_PZER;
`ifdef HUB_SC_ONE_DETECT_EN
        else if (mag == {1'b1, {(W-2){1'b0}}})
            classify = v[W-1] ? CASE_NONE1 : CASE_PONE;
`endif
    endfunction

    // Stage 1 registers
    logic             s1_valid;
    logic [2:0]       s1_xc;
    logic [2:0]       s1_yc;
    logic             s1_s;
    logic [TAG_W-1:0] s1_tag;
`ifdef HUB_SC_ONE_DETECT_EN
    logic [W-2:0]     s1_xm;
    logic [W-2:0]     s1_ym;
`endif

    // Stage 2 (output) registers
    logic             s2_valid;
    logic [2:0]       s2_xc;
    logic [2:0]       s2_yc;
    logic             s2_bypass;
    logic             s2_inv;
    logic [W-1:0]     s2_res;
    logic [TAG_W-1:0] s2_tag;

    // Pipeline advance: stage 2 loads when empty or drained this cycle;
    // stage 1 advances when stage 2 takes its entry or it is empty.
    logic ld2;
    logic adv1;
    assign ld2      = out_ready || !s2_valid;
    assign adv1     = ld2 || !s1_valid;
    assign in_ready = !rst && adv1;

    // Resolution of the stage-1 entry, first matching rule wins.
    logic         x_inf, y_inf, x_zero, y_zero;
    logic         r_bypass;
    logic         r_inv;
    logic [W-1:0] r_res;

    assign x_inf  = (s1_xc == CASE_PINF) || (s1_xc == CASE_NINF);
    assign y_inf  = (s1_yc == CASE_PINF) || (s1_yc == CASE_NINF);
    assign x_zero = (s1_xc == CASE_PZER) || (s1_xc == CASE_NZER);
    assign y_zero = (s1_yc == CASE_PZER) || (s1_yc == CASE_NZER);

    always_comb begin
        r_bypass = 1'b0;
        r_inv    = 1'b0;
        r_res    = '0;
        if ((x_inf && y_zero) || (y_inf && x_zero)) begin
            r_bypass = 1'b1;
            r_inv    = 1'b1;
            r_res    = {s1_s, {(W-1){1'b1}}};
        end else if (x_inf || y_inf) begin
            r_bypass = 1'b1;
            r_res    = {s1_s, {(W-1){1'b1}}};
        end else if (x_zero || y_zero) begin
            r_bypass = 1'b1;
            r_res    = {s1_s, {(W-1){1'b0}}};
`ifdef HUB_SC_ONE_DETECT_EN
        end else if ((s1_xc == CASE_PONE) || (s1_xc == CASE_NONE1)) begin
            r_bypass = 1'b1;
            r_res    = {s1_s, s1_ym};
        end else if ((s1_yc == CASE_PONE) || (s1_yc == CASE_NONE1)) begin
            r_bypass = 1'b1;
            r_res    = {s1_s, s1_xm};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_xc     <= '0;
            s1_yc     <= '0;
            s1_s      <= 1'b0;
            s1_tag    <= '0;
`ifdef HUB_SC_ONE_DETECT_EN
            s1_xm     <= '0;
            s1_ym     <= '0;
`endif
            s2_valid  <= 1'b0;
            s2_xc     <= '0;
            s2_yc     <= '0;
            s2_bypass <= 1'b0;
            s2_inv    <= 1'b0;
            s2_res    <= '0;
            s2_tag    <= '0;
        end else begin
            if (ld2) begin
                s2_valid  <= s1_valid;
                s2_xc     <= s1_xc;
                s2_yc     <= s1_yc;
                s2_bypass <= r_bypass;
                s2_inv    <= r_inv;
                s2_res    <= r_res;
                s2_tag    <= s1_tag;
            end
            if (adv1) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_xc  <= classify(X);
                    s1_yc  <= classify(Y);
                    s1_s   <= X[W-1] ^ Y[W-1];
                    s1_tag <= in_tag;
`ifdef HUB_SC_ONE_DETECT_EN
                    s1_xm  <= X[W-2:0];
                    s1_ym  <= Y[W-2:0];
`endif
                end
            end
        end
    end

    assign out_valid  = s2_valid;
    assign x_case     = s2_xc;
    assign y_case     = s2_yc;
    assign bypass     = s2_bypass;
    assign invalid_op = s2_inv;
    assign sc_result  = s2_res;
    assign out_tag    = s2_tag;

endmodule

// File: tb/tb_hub_special_case_pipe.sv
module tb_hub_special_case_pipe;

  localparam int W = 32;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  X;
  logic [W-1:0]  Y;
  logic [3:0]    in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [2:0]    x_case;
  logic [2:0]    y_case;
  logic          bypass;
  logic          invalid_op;
  logic [W-1:0]  sc_result;
  logic [3:0]    out_tag;

  hub_special_case_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .X(X), .Y(Y), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .x_case(x_case), .y_case(y_case), .bypass(bypass), .invalid_op(invalid_op),
    .sc_result(sc_result), .out_tag(out_tag)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- counters / checker ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [2:0]  xc;
    logic [2:0]  yc;
    logic        byp;
    logic        inv;
    logic [31:0] res;
    logic [3:0]  tag;
  } exp_t;

  function automatic int cls(input logic [31:0] v);
    int code;
    logic [30:0] mag;
    mag  = v[30:0];
    code = 0;
    if (mag == 31'h7FFF_FFFF)      code = v[31] ? 2 : 1;
    else if (mag == 31'h0)         code = v[31] ? 4 : 3;
`ifdef HUB_SC_ONE_DETECT_EN
    else if (mag == 31'h4000_0000) code = v[31] ? 6 : 5;
`endif
    return code;
  endfunction

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic [3:0] tag);
    exp_t e;
    int cx, cy;
    bit s, xi, yi, xz, yz, xo, yo;
    cx = cls(x);
    cy = cls(y);
    s  = x[31] ^ y[31];
    xi = (cx == 1 || cx == 2);
    yi = (cy == 1 || cy == 2);
    xz = (cx == 3 || cx == 4);
    yz = (cy == 3 || cy == 4);
    xo = (cx == 5 || cx == 6);
    yo = (cy == 5 || cy == 6);
    e.xc  = cx[2:0];
    e.yc  = cy[2:0];
    e.tag = tag;
    e.byp = 1'b1;
    e.inv = 1'b0;
    if ((xi && yz) || (yi && xz)) begin
      e.inv = 1'b1;
      e.res = {s, 31'h7FFF_FFFF};
    end else if (xi || yi) e.res = {s, 31'h7FFF_FFFF};
    else if (xz || yz)     e.res = {s, 31'h0};
    else if (xo)           e.res = {s, y[30:0]};
    else if (yo)           e.res = {s, x[30:0]};
    else begin
      e.byp = 1'b0;
      e.res = 32'h0;
    end
    return e;
  endfunction

  // ---------------- scoreboard / compare process ----------------
  exp_t exp_q[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   acc_cnt = 0;
  logic rst_q = 1'b1;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  always @(negedge clk) begin
    exp_t h;
    if (rst_q) exp_q.delete();
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("spurious_out_valid", {31'h0, out_valid}, 32'h0);
      end else begin
        h = exp_q[0];
        chk("sb_x_case", {29'h0, x_case}, {29'h0, h.xc});
        chk("sb_y_case", {29'h0, y_case}, {29'h0, h.yc});
        chk("sb_bypass", {31'h0, bypass}, {31'h0, h.byp});
        chk("sb_invalid_op", {31'h0, invalid_op}, {31'h0, h.inv});
        chk("sb_sc_result", sc_result, h.res);
        chk("sb_out_tag", {28'h0, out_tag}, {28'h0, h.tag});
        if (out_ready) begin
          void'(exp_q.pop_front());
          pop_cyc.push_back(cyc);
        end
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(X, Y, in_tag));
      acc_cnt++;
    end
  end

  // ---------------- stimulus table ----------------
  logic [31:0] tx [10] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 32'hC0000000,
                           32'h3F800000, 32'h12345678, 32'h7FFFFFFE, 32'h40000001, 32'hFFFFFFFF};
  logic [31:0] ty [10] = '{32'h00000000, 32'h3F800000, 32'hC0000000, 32'h80000000, 32'h12345678,
                           32'h40000000, 32'h3ABCDEF0, 32'h00000001, 32'hBFFFFFFF, 32'h7FFFFFFF};

  // ---------------- driver tasks ----------------
  // All drivers start and end #1 after a rising edge.
  task automatic send(input logic [31:0] x, input logic [31:0] y, input logic [3:0] tag, input bit rnd);
    bit acc;
    acc      = 1'b0;
    X        = x;
    Y        = y;
    in_tag   = tag;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) chk("send_timeout", 32'h0, 32'h1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) idle(1);
    idle(2);
    chk("drain_empty", exp_q.size(), 32'h0);
  endtask

  // Single pair into an empty pipe: checks the 2-cycle latency and literal outputs.
  task automatic lat(input string nm, input logic [31:0] x, input logic [31:0] y, input logic [3:0] tag,
                     input logic [2:0] exc, input logic [2:0] eyc, input logic eb, input logic ei,
                     input logic [31:0] er);
    out_ready = 1'b1;
    X = x; Y = y; in_tag = tag; in_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_cycle1_out_valid"}, {31'h0, out_valid}, 32'h0);
    @(negedge clk);
    chk({nm, "_cycle2_out_valid"}, {31'h0, out_valid}, 32'h1);
    chk({nm, "_x_case"}, {29'h0, x_case}, {29'h0, exc});
    chk({nm, "_y_case"}, {29'h0, y_case}, {29'h0, eyc});
    chk({nm, "_bypass"}, {31'h0, bypass}, {31'h0, eb});
    chk({nm, "_invalid_op"}, {31'h0, invalid_op}, {31'h0, ei});
    chk({nm, "_sc_result"}, sc_result, er);
    chk({nm, "_out_tag"}, {28'h0, out_tag}, {28'h0, tag});
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int idx, acc0, b, a;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    X = '0; Y = '0; in_tag = '0;
    idle(2);
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_outputs", {23'h0, x_case, y_case, bypass, invalid_op, out_tag}, 32'h0);
    chk("rst_sc_result", sc_result, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1;

    // Literal vectors
`ifdef HUB_SC_ONE_DETECT_EN
    lat("x_is_one", 32'h40000000, 32'hC1234567, 4'h3, 3'd5, 3'd0, 1'b1, 1'b0, 32'hC1234567);
    lat("both_one", 32'h40000000, 32'h40000000, 4'h6, 3'd5, 3'd5, 1'b1, 1'b0, 32'h40000000);
`else
    lat("x_is_one", 32'h40000000, 32'hC1234567, 4'h3, 3'd0, 3'd0, 1'b0, 1'b0, 32'h00000000);
    lat("both_one", 32'h40000000, 32'h40000000, 4'h6, 3'd0, 3'd0, 1'b0, 1'b0, 32'h00000000);
`endif
    lat("inf_x_negzero", 32'h7FFFFFFF, 32'h80000000, 4'h4, 3'd1, 3'd4, 1'b1, 1'b1, 32'hFFFFFFFF);
    lat("normal", 32'h12345678, 32'h3ABCDEF0, 4'h5, 3'd0, 3'd0, 1'b0, 1'b0, 32'h00000000);
    lat("neginf_x_normal", 32'hFFFFFFFF, 32'h3F800000, 4'h7, 3'd2, 3'd0, 1'b1, 1'b0, 32'hFFFFFFFF);
    lat("zero_x_normal", 32'h00000000, 32'hBF800000, 4'h8, 3'd3, 3'd0, 1'b1, 1'b0, 32'h80000000);

    // Back-to-back, tags 1..8, must leave on consecutive cycles
    b = pop_cyc.size();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(tx[i], ty[i], 4'(i + 1), 1'b0);
    for (int i = 0; i < 20 && pop_cyc.size() < b + 8; i++) idle(1);
    chk("b2b_count", pop_cyc.size() - b, 32'd8);
    if (pop_cyc.size() >= b + 8)
      chk("b2b_consecutive", pop_cyc[b + 7] - pop_cyc[b], 32'd7);

    // Backpressure: 5 stalled cycles accept exactly 2 pairs
    out_ready = 1'b0;
    acc0 = acc_cnt;
    idx = 0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      X = tx[idx]; Y = ty[idx]; in_tag = 4'(idx + 9);
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      #1;
      if (a != 0) idx++;
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
    chk("stall_accepted", acc_cnt - acc0, 32'd2);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = idx; i < 6; i++) send(tx[i], ty[i], 4'(i + 9), 1'b0);
    drain();

    // Reset with two entries in flight
    out_ready = 1'b0;
    send(tx[0], ty[0], 4'hA, 1'b0);
    send(tx[1], ty[1], 4'hB, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrst_out_tag", {28'h0, out_tag}, 32'h0);
    chk("midrst_in_ready", {31'h0, in_ready}, 32'h1);
    @(posedge clk);
    #1 out_ready = 1'b1;
    idle(5);
    lat("after_rst", 32'hFFFFFFFF, 32'h7FFFFFFF, 4'hC, 3'd2, 3'd1, 1'b1, 1'b0, 32'hFFFFFFFF);

    // Table with random output backpressure
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 10; i++) send(tx[i], ty[i], 4'(i + r), 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/hub_special_case_pipe.md
HUB_SPECIAL_CASE_PIPE -- requirements
Module: hub_special_case_pipe

Interface
REQ-001 Parameter M, default 23, mantissa width.
REQ-002 Parameter E, default 8, exponent width.
REQ-003 Parameter TAG_W, default 4, width of the opaque tag carried alongside each operand pair.
REQ-004 Clock and reset SHALL be: one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  operand pair X, Y, in_tag presented.
REQ-008 in_ready  output  1  block accepts the pair this cycle.
REQ-009 X, Y  input  E+M+1 each  HUB operands, sign at MSB.
REQ-010 in_tag  input  TAG_W  opaque tag.
REQ-011 out_valid  output  1  result registers hold a valid entry.
REQ-012 out_ready  input  1  downstream consumes the entry this cycle.
REQ-013 x_case, y_case  output  3 each  class codes of X and Y.
REQ-014 bypass  output  1  special result valid; main multiplier result SHALL be overridden.
REQ-015 invalid_op  output  1  inf times zero detected.
REQ-016 sc_result  output  E+M+1  special product value, 0 when bypass=0.
REQ-017 out_tag  output  TAG_W  tag of the entry.

Function
REQ-018 Class codes: 0 none, 1 +inf, 2 -inf, 3 +0, 4 -0, 5 +1, 6 -1; code 7 is never produced.
REQ-019 inf: bits [E+M-1:0] all ones. Zero: bits [E+M-1:0] all zero. One: bit E+M-1 set and bits [E+M-2:0] zero. Sign from bit E+M in every case.
REQ-020 Stage 1 registers x_case, y_case, s = X[E+M]^Y[E+M], X, Y and tag. Stage 2 registers the resolved outputs.
REQ-021 Latency: exactly 2 cycles from acceptance (in_valid&&in_ready) to out_valid, with no backpressure.
REQ-022 Resolution priority, first match wins:
- (a) one operand inf and the other zero -> bypass=1, invalid_op=1, sc_result={s, all ones}.
- (b) either operand inf -> bypass=1, sc_result={s, all ones}.
- (c) either operand zero -> bypass=1, sc_result={s, all zeros}.
- (d) X is ±1 -> bypass=1, sc_result={s, Y[E+M-1:0]}.
- (e) Y is ±1 -> bypass=1, sc_result={s, X[E+M-1:0]}.
- else bypass=0, invalid_op=0, sc_result=0.
REQ-023 Stage 2 SHALL load when out_ready || !out_valid. Stage 1 SHALL advance when stage 2 loads or stage 1 is empty. in_ready is the stage-1 advance condition. Full throughput is one pair per cycle.
REQ-024 While out_valid=1 and out_ready=0, every output SHALL hold stable. The pipeline holds at most 2 entries. No entry is dropped or duplicated, and order is preserved.
REQ-025 in_ready SHALL depend only on registered state and out_ready, with no combinational path from in_valid.
REQ-026 Accept and consume in the same cycle with both stages full SHALL shift the entries with no bubble.

Reset
REQ-027 When rst=1 at a clock edge, both stage valids SHALL clear, so out_valid=0. Outputs x_case, y_case, bypass, invalid_op, sc_result and out_tag SHALL be 0.
REQ-028 in_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after rst deasserts.
REQ-029 Reset mid-operation SHALL discard in-flight entries, and none SHALL appear afterwards.

Configuration
REQ-030 Macro HUB_SC_ONE_DETECT_EN. When defined, codes 5/6 and rules (d) and (e) are active.
REQ-031 When HUB_SC_ONE_DETECT_EN is undefined, ±1 operands SHALL classify as 0 and rules (d) and (e) are removed. Codes 1-4, timing and handshake are unchanged.

Verification (M=23, E=8)
REQ-032 X=0x40000000, Y=0xC1234567, out_ready=1 -> 2 cycles later: x_case=5, y_case=0, bypass=1, sc_result=0xC1234567.
REQ-033 X=0x7FFFFFFF, Y=0x80000000 -> x_case=1, y_case=4, bypass=1, invalid_op=1, sc_result=0xFFFFFFFF.
REQ-034 X=0x12345678, Y=0x3ABCDEF0 -> x_case=0, y_case=0, bypass=0, sc_result=0. Back-to-back pairs with tags 1..8 -> 8 outputs on consecutive cycles, tags in order.
REQ-035 out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 pairs accepted, in_ready=0 thereafter, outputs stable. out_ready=1 -> remaining pairs follow in order with no loss.
REQ-036 Two pairs in flight, rst pulsed 1 cycle -> out_valid=0, no stale output afterwards. Next accepted pair emerges after 2 cycles.
REQ-037 Macro undefined, X=0x40000000, Y=0x40000000 -> x_case=0, y_case=0, bypass=0.
